// File: rtl/phase_meas_pkg.sv
// Shared definitions for the phase-sample measurement path.
// Word layout is shared with the read-side unpacker.
package phase_meas_pkg;

  localparam int DATA_W    = 32;
  localparam int SAMPLE_W  = 24;
  localparam int SEQ_WIDTH = DATA_W - SAMPLE_W;
  localparam int AVG_LSB   = 0;
  localparam int SEQ_LSB   = SAMPLE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/phase_decim_acc.sv
// Block accumulator: sums 2^DECIM_LOG2 signed samples and emits their average.
// Round-half-up is enabled by defining PHASE_DECIM_ROUND_EN; floor otherwise.
module phase_decim_acc #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int DECIM_LOG2   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_vld,
  input  logic [SAMPLE_WIDTH-1:0] in,
  output logic                    out_vld,
  output logic [SAMPLE_WIDTH-1:0] out_avg
);

  localparam int AW = SAMPLE_WIDTH + DECIM_LOG2;
  localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << DECIM_LOG2) - 1);
`ifdef PHASE_DECIM_ROUND_EN
  localparam logic [AW-1:0] RND = AW'((1 << DECIM_LOG2) >> 1);
`else
  localparam logic [AW-1:0] RND = '0;
`endif

  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] sum, rnd_sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign sum     = acc_q + AW'($signed(in));
  assign rnd_sum = sum + RND;
  assign last    = (cnt_q == CNT_LAST);
  assign out_vld = in_vld & last;
  assign out_avg = SAMPLE_WIDTH'($signed(rnd_sum) >>> DECIM_LOG2);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_vld) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/phase_decim_writer.sv
// Write-side producer: decimates phase samples and feeds the async FIFO.
// Build option: PHASE_DECIM_ROUND_EN selects round-half-up averaging.
module phase_decim_writer
  import phase_meas_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 24,
  parameter int DECIM_LOG2   = 2,
  parameter int OVF_WIDTH    = 16
) (
  input  logic                    wr_clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    sample_vld,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic                    fifo_full,
  output logic                    data_in_vld,
  output logic [DATA_WIDTH-1:0]   data_in,
  output logic                    busy,
  output logic [OVF_WIDTH-1:0]    overflow_cnt
);

  localparam int SEQ_W = DATA_WIDTH - SAMPLE_WIDTH;

  state_e                  state_q, state_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [DATA_WIDTH-1:0]   pend_q, pend_d;
  logic [SEQ_W-1:0]        seq_q, seq_d;
  logic [OVF_WIDTH-1:0]    ovf_q, ovf_d;
  logic                    acc_clr, acc_vld;
  logic                    blk_vld;
  logic [SAMPLE_WIDTH-1:0] blk_avg;
  logic                    wr, load, drop;

  assign acc_clr = (state_q == ST_IDLE);
  assign acc_vld = (state_q == ST_RUN) & sample_vld;

  phase_decim_acc #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .DECIM_LOG2   (DECIM_LOG2)
  ) u_acc (
    .clk     (wr_clk),
    .rst     (rst),
    .clr     (acc_clr),
    .in_vld  (acc_vld),
    .in      (sample),
    .out_vld (blk_vld),
    .out_avg (blk_avg)
  );

  // The pending slot frees up in the same cycle it is written.
  assign wr   = pend_vld_q & ~fifo_full;
  assign load = blk_vld & (~pend_vld_q | wr);
  assign drop = blk_vld & ~load;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start && !stop) state_d = ST_RUN;
      ST_RUN:   if (stop) state_d = ST_DRAIN;
      ST_DRAIN: if (!pend_vld_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_vld_d = load | (pend_vld_q & ~wr);
    pend_d     = load ? {seq_q, blk_avg} : pend_q;
    seq_d      = blk_vld ? seq_q + SEQ_W'(1) : seq_q;
    ovf_d      = ovf_q;
    if (drop && ovf_q != '1) ovf_d = ovf_q + OVF_WIDTH'(1);
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      seq_q      <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      seq_q      <= seq_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data_in_vld  = wr;
  assign data_in      = pend_q;
  assign busy         = (state_q != ST_IDLE);
  assign overflow_cnt = ovf_q;

endmodule

// File: doc/phase_decim_writer.md
# phase_decim_writer

Write-side producer for the phase-sample async FIFO, running in the `wr_clk` (measurement) domain. It accepts raw signed phase samples from the measurement datapath and averages each block of 2^DECIM_LOG2 samples. Each average is tagged with a sequence number and pushed into the FIFO's write interface under `fifo_full` back-pressure. Results that cannot be stored are dropped and counted, so the read-side software can detect gaps.

## Interface
- `DATA_WIDTH`, 32, FIFO word width; must match the FIFO.
- `SAMPLE_WIDTH`, 24, signed phase-sample width. Must be < `DATA_WIDTH`.
- `DECIM_LOG2`, 2, log2 of samples averaged per output word (0..8).
- `OVF_WIDTH`, 16, width of the dropped-result counter.
- `wr_clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle pulse; begins a capture run.
- `stop`  in  1  single-cycle pulse; ends the capture run.
- `sample_vld`  in  1  qualifies `sample`.
- `sample`  in  SAMPLE_WIDTH  signed phase sample.
- `fifo_full`  in  1  FIFO full flag; registered in the FIFO and 1 during FIFO reset.
- `data_in_vld`  out  1  write strobe to the FIFO.
- `data_in`  out  DATA_WIDTH  word `{seq[DATA_WIDTH-SAMPLE_WIDTH-1:0], avg[SAMPLE_WIDTH-1:0]}`.
- `busy`  out  1  state is not IDLE.
- `overflow_cnt`  out  OVF_WIDTH  count of dropped results; saturating.

## Operation
- **FSM states.** IDLE, RUN, DRAIN.
  - IDLE→RUN on `start`. If `start` and `stop` arrive in the same cycle while in IDLE, the FSM stays in IDLE.
  - RUN→DRAIN on `stop`. `start` is ignored outside IDLE.
  - DRAIN→IDLE in the first cycle with no pending word.
- **Entering RUN.** Clear the accumulator and sample count. `seq` and `overflow_cnt` are *not* cleared; only `rst` clears them.
- **Sample acceptance.** A sample is accepted when `sample_vld` is high in state RUN, and only then. Accepted samples are sign-extended to `SAMPLE_WIDTH+DECIM_LOG2` bits and summed.
- **Block completion.** On the 2^DECIM_LOG2-th accepted sample, including that sample:
  - `avg = (acc + sample) >>> DECIM_LOG2` (arithmetic shift, floor), truncated to `SAMPLE_WIDTH` bits.
  - The accumulator and count restart at 0.
  - The result takes tag `seq`, then `seq` increments modulo 2^(DATA_WIDTH-SAMPLE_WIDTH).
- **Single pending register.**
  - A completed result loads into the pending register if it is empty, or if the pending word is written in that same cycle.
  - Otherwise the new result is dropped and `overflow_cnt` increments, saturating at all-ones. The dropped result's `seq` is still consumed.
- **FIFO handshake.** `data_in_vld = pending_vld & ~fifo_full`.
  - A word is written in every cycle where `data_in_vld` is 1. On that edge the pending register clears, unless it is reloaded in the same cycle.
  - `data_in` always shows the pending register. It is meaningful only while `data_in_vld` is 1.
- **`stop` mid-block.** The partial accumulation is discarded and no word is produced for it. A pending word is still delivered, during DRAIN.
- **`stop` on the completing sample.** The completed result is kept and goes into the pending register.
- **`rst` at any time** returns the block to its reset state; a pending word is lost.

## Timing
- **Reset values.** `data_in_vld`=0, `data_in`=0, `busy`=0, `overflow_cnt`=0. Internally, `seq`=0 and the FSM is in IDLE.
- **State change.** `start` sampled at edge k → `busy`=1 after edge k. The first sample can be accepted at edge k+1.
- **Output latency.** Completing sample accepted at edge k → pending word valid after edge k. `data_in_vld`=1 in that cycle if `fifo_full`=0, and the word is written at edge k+1.
- **Throughput.** One word per cycle sustained when DECIM_LOG2=0 and `fifo_full`=0.
- **`data_in_vld` is combinational from `fifo_full`.** This is legal only because `fifo_full` is a register output in the FIFO.

## Configuration
- **`PHASE_DECIM_ROUND_EN` defined.** Add 2^(DECIM_LOG2-1) before the shift (round half up). When DECIM_LOG2=0 no constant is added.
- **`PHASE_DECIM_ROUND_EN` undefined.** Plain arithmetic-shift floor.

## Structure
- **Shared package `phase_meas_pkg`:**
  - FSM state enum (IDLE/RUN/DRAIN).
  - `SEQ_WIDTH` = `DATA_WIDTH-SAMPLE_WIDTH` constant.
  - Word field positions (SEQ_LSB, AVG_LSB), shared with the read-side unpacker.
- **Sub-module `phase_decim_acc`.** Contains the accumulator, sample counter, and shift/round logic. Its ports are `clk`, `rst`, `clr`, `in_vld`, `in`, `out_vld`, `out_avg`. The top level keeps the FSM, the pending register, `seq`, and `overflow_cnt`.

## Test plan
All scenarios use DECIM_LOG2=2, SAMPLE_WIDTH=24, DATA_WIDTH=32.
- **Positive average.** `start`; samples 4, 8, 12, 16 with `fifo_full`=0 → one write with `data_in`=0x0000000A, one cycle after the 4th sample edge.
- **Negative average.** Samples −1, −2, −3, −4 → `data_in`=0x00FFFFFD (floor −2.5 = −3). With `PHASE_DECIM_ROUND_EN` defined → 0x00FFFFFE (−2).
- **Back-pressure and drops.** Hold `fifo_full`=1 through 12 samples, then release → `overflow_cnt`=2. The single write that follows carries seq 0. The next completed block carries seq 3.
- **`stop` mid-block.** 2 samples, then `stop` → no write; `busy` falls the cycle after DRAIN sees pending empty. A new `start` plus 4 samples of value 1 → `data_in`=0x00000001 with the correct next seq.
- **Reset mid-run.** Assert `rst` with a pending word and `fifo_full`=1 → all outputs return to their reset values, no write occurs, and the next run's first word carries seq 0.
- **Simultaneous events.** `start` and `stop` together in IDLE → `busy` stays 0. Pending write and new block completion in the same cycle → both words written on consecutive cycles, `overflow_cnt` unchanged.
